setup_cfg: RTL and testbench

SETUP_CFG -- requirements
Module: setup_cfg

---
 rtl/setup_cfg_pkg.sv | 52 +++++
 rtl/setup_cfg_if.sv | 26 ++
 rtl/senha_valida.sv | 44 ++++
 rtl/setup_cfg.sv | 197 +++++++++++++++++++
 tb/tb_setup_cfg.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/setup_cfg_pkg.sv
// Shared types and constants for the setup configuration editor.
// - senhaPac_t    : 20 BCD digits, digit 0 in bits [3:0]
// - bcdPac_t      : six display digits, BCD0 in element 0
// - setupCfgPac_t : full configuration record (committed and work copies)
// - clamp7        : saturate a 7-bit value into [lo, hi]
// - cfg_reset     : power-on configuration
package setup_cfg_pkg;

  localparam int unsigned SENHAS_MAX = 5;
  localparam int unsigned SENHA_DIG  = 20;

  typedef logic [SENHA_DIG*4-1:0] senhaPac_t;
  typedef logic [5:0][3:0]        bcdPac_t;

  typedef struct packed {
    logic                        bip_status;
    logic [6:0]                  bip_time;
    logic [6:0]                  tranca_aut_time;
    senhaPac_t                   senha_master;
    senhaPac_t [SENHAS_MAX-1:0]  senha;
  } setupCfgPac_t;

  // Keypad sentinels: skip field, save now, no-op
  localparam senhaPac_t SENHA_SKIP = {SENHA_DIG{4'hF}};
  localparam senhaPac_t SENHA_SAVE = {SENHA_DIG{4'hB}};
  localparam senhaPac_t SENHA_NONE = {SENHA_DIG{4'hE}};

  localparam senhaPac_t  SENHA_MASTER_RST = {{(SENHA_DIG-4){4'hF}}, 16'h1234};
  localparam logic [3:0] BCD_BLANK        = 4'hB;

  typedef enum logic [2:0] {
    StIdle, StHabBip, StTBip, StTTrc, StSMaster, StSUser, StSave, StAbort
  } state_e;

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic setupCfgPac_t cfg_reset();
    setupCfgPac_t c;
    c.bip_status      = 1'b1;
    c.bip_time        = 7'd5;
    c.tranca_aut_time = 7'd5;
    c.senha_master    = SENHA_MASTER_RST;
    for (int unsigned i = 0; i < SENHAS_MAX; i++) c.senha[i] = SENHA_SKIP;
    return c;
  endfunction

endpackage

// File: rtl/setup_cfg_if.sv
// Keypad/display/configuration bundle of the setup editor.
// master: keypad side (drives setup_on, digitos_*), observes results.
// slave : setup_cfg block.
interface setup_cfg_if;
  import setup_cfg_pkg::*;

  logic         setup_on;
  senhaPac_t    digitos_value;
  logic         digitos_valid;
  logic         display_en;
  bcdPac_t      bcd_pac;
  setupCfgPac_t data_setup_new;
  logic         data_setup_ok;
  logic         setup_abort;
  logic         entry_err;

  modport master (
    output setup_on, digitos_value, digitos_valid,
    input  display_en, bcd_pac, data_setup_new, data_setup_ok, setup_abort, entry_err
  );

  modport slave (
    input  setup_on, digitos_value, digitos_valid,
    output display_en, bcd_pac, data_setup_new, data_setup_ok, setup_abort, entry_err
  );
endinterface

// File: rtl/senha_valida.sv
// Combinational password check.
// senha : 20-digit keypad entry
// ok    : length within [PW_MIN_DIG, PW_MAX_DIG], digits BCD, rest all F
// len   : count of contiguous non-F digits starting at digit 0
module senha_valida
  import setup_cfg_pkg::*;
#(
  parameter int unsigned PW_MIN_DIG = 4,
  parameter int unsigned PW_MAX_DIG = 12
) (
  input  senhaPac_t  senha,
  output logic       ok,
  output logic [4:0] len
);

  localparam logic [4:0] LenMin = 5'(PW_MIN_DIG);
  localparam logic [4:0] LenMax = 5'(PW_MAX_DIG);

  logic       run;
  logic       dig_ok;
  logic [3:0] d;
  logic [4:0] cnt;

  always_comb begin
    cnt    = '0;
    run    = 1'b1;
    dig_ok = 1'b1;
    d      = '0;
    for (int unsigned i = 0; i < SENHA_DIG; i++) begin
      d = senha[4*i +: 4];
      if (run && d != 4'hF) begin
        cnt = cnt + 5'd1;
        if (d > 4'd9) dig_ok = 1'b0;
      end else begin
        // Past the first F everything must stay F (no gaps)
        run = 1'b0;
        if (d != 4'hF) dig_ok = 1'b0;
      end
    end
    len = cnt;
    ok  = dig_ok && (cnt >= LenMin) && (cnt <= LenMax);
  end

endmodule

// File: rtl/setup_cfg.sv
// Setup configuration editor: walks the operator through bip enable, bip time,
// auto-lock time, master password and NUM_SENHAS user passwords, then commits.
// clk, rst : clock, synchronous active-low reset
// bus      : keypad inputs, display outputs, committed config and status pulses
module setup_cfg
  import setup_cfg_pkg::*;
#(
  parameter int unsigned NUM_SENHAS   = 4,
  parameter int unsigned PW_MIN_DIG   = 4,
  parameter int unsigned PW_MAX_DIG   = 12,
  parameter int unsigned T_MIN        = 5,
  parameter int unsigned T_MAX        = 60,
  parameter int unsigned INACT_CYCLES = 30_000_000
) (
  input logic        clk,
  input logic        rst,
  setup_cfg_if.slave bus
);

  localparam int unsigned    CntW    = (INACT_CYCLES > 2) ? $clog2(INACT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(INACT_CYCLES - 1);
  localparam logic [2:0]     IdxLast = 3'(NUM_SENHAS - 1);
  localparam logic [6:0]     TMin    = 7'(T_MIN);
  localparam logic [6:0]     TMax    = 7'(T_MAX);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  setupCfgPac_t    work_q, work_d, cfg_q, cfg_d;
  logic            ok_q, abort_q, err_q, err_d;

  senhaPac_t  val;
  logic [3:0] d0, d1;
  logic [6:0] tval;
  logic       edit, advance, pw_ok, pw_accept;
  logic [4:0] pw_len;
  bcdPac_t    bcd;

  assign val  = bus.digitos_value;
  assign d0   = val[3:0];
  assign d1   = val[7:4];
  assign tval = 7'(d1) * 7'd10 + 7'(d0);
  assign edit = state_q inside {StHabBip, StTBip, StTTrc, StSMaster, StSUser};

  senha_valida #(
    .PW_MIN_DIG(PW_MIN_DIG),
    .PW_MAX_DIG(PW_MAX_DIG)
  ) u_senha_valida (
    .senha(val),
    .ok   (pw_ok),
    .len  (pw_len)
  );

  // An empty entry is never a password, even with PW_MIN_DIG = 0
  assign pw_accept = pw_ok & (|pw_len);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.setup_on) begin
          work_d  = cfg_q;
          idx_d   = '0;
          state_d = StHabBip;
        end
      end
      StSave: begin
        cfg_d   = work_q;
        state_d = StIdle;
      end
      StAbort: state_d = StIdle;
      default: begin
        if (bus.digitos_valid) begin
          if (val == SENHA_SKIP) begin
            advance = 1'b1;
          end else if (val == SENHA_SAVE) begin
            state_d = StSave;
          end else if (val != SENHA_NONE) begin
            unique case (state_q)
              StHabBip: begin
                if (d0 <= 4'd1) begin
                  work_d.bip_status = d0[0];
                  advance           = 1'b1;
                end else err_d = 1'b1;
              end
              StTBip, StTTrc: begin
                if (d0 > 4'd9 || d1 > 4'd9) begin
                  err_d = 1'b1;
                end else begin
                  if (state_q == StTBip) work_d.bip_time = clamp7(tval, TMin, TMax);
                  else work_d.tranca_aut_time = clamp7(tval, TMin, TMax);
                  advance = 1'b1;
                end
              end
              StSMaster: begin
                if (pw_accept) begin
                  work_d.senha_master = val;
                  advance             = 1'b1;
                end else err_d = 1'b1;
              end
              StSUser: begin
                if (pw_accept) begin
                  work_d.senha[idx_q] = val;
                  advance             = 1'b1;
                end else err_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (advance) begin
      unique case (state_q)
        StHabBip:  state_d = StTBip;
        StTBip:    state_d = StTTrc;
        StTTrc:    state_d = StSMaster;
        StSMaster: begin
          state_d = StSUser;
          idx_d   = '0;
        end
        StSUser: begin
          if (idx_q == IdxLast) state_d = StSave;
          else idx_d = idx_q + 3'd1;
        end
        default: ;
      endcase
    end

    // Any keypad strobe or field change restarts the idle timer
    if (!edit || bus.digitos_valid || state_d != state_q || idx_d != idx_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      state_d = StAbort;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      work_q  <= cfg_reset();
      cfg_q   <= cfg_reset();
      ok_q    <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      cfg_q   <= cfg_d;
      // Pulses line up with the SAVE/ABORT state cycle
      ok_q    <= (state_d == StSave);
      abort_q <= (state_d == StAbort);
      err_q   <= err_d;
    end
  end

  always_comb begin
    bcd = {6{BCD_BLANK}};
    unique case (state_q)
      StHabBip: begin
        bcd[5] = 4'd1;
        bcd[0] = d0;
      end
      StTBip, StTTrc: begin
        bcd[5] = (state_q == StTBip) ? 4'd2 : 4'd3;
        bcd[1] = d1;
        bcd[0] = d0;
      end
      StSMaster: bcd[5] = 4'd4;
      StSUser:   bcd[5] = 4'd5 + {1'b0, idx_q};
      default: ;
    endcase
  end

  assign bus.display_en     = (state_q != StIdle);
  assign bus.bcd_pac        = bcd;
  assign bus.data_setup_new = cfg_q;
  assign bus.data_setup_ok  = ok_q;
  assign bus.setup_abort    = abort_q;
  assign bus.entry_err      = err_q;

endmodule

// File: tb/tb_setup_cfg.sv
module tb_setup_cfg;
  import setup_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  setup_cfg_if bus ();

  setup_cfg #(
    .NUM_SENHAS  (2),
    .PW_MIN_DIG  (4),
    .PW_MAX_DIG  (12),
    .T_MIN       (5),
    .T_MAX       (60),
    .INACT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    senhaPac_t   val;
    logic [23:0] bcd_pre;
    logic        err;
    logic [3:0]  bcd5;
    logic        ok;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic senhaPac_t pw(input logic [79:0] dig, input int n);
    senhaPac_t v = SENHA_SKIP;
    for (int i = 0; i < n; i++) v[4*i +: 4] = dig[4*i +: 4];
    return v;
  endfunction

  task automatic send(input senhaPac_t v);
    bus.digitos_value = v;
    bus.digitos_valid = 1'b1;
    @(negedge clk);
    bus.digitos_valid = 1'b0;
  endtask

  task automatic enter_setup();
    bus.setup_on = 1'b1;
    @(negedge clk);
    bus.setup_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ab;
    int first;
    bus.setup_on      = 1'b0;
    bus.digitos_valid = 1'b0;
    bus.digitos_value = SENHA_NONE;

    vec[0] = '{pw(80'h0, 1),      24'h1BBBB0, 1'b0, 4'h2, 1'b0};
    vec[1] = '{pw(80'h0A, 2),     24'h2BBB0A, 1'b1, 4'h2, 1'b0};
    vec[2] = '{pw(80'h03, 2),     24'h2BBB03, 1'b0, 4'h3, 1'b0};
    vec[3] = '{pw(80'h99, 2),     24'h3BBB99, 1'b0, 4'h4, 1'b0};
    vec[4] = '{pw(80'h123, 3),    24'h4BBBBB, 1'b1, 4'h4, 1'b0};
    vec[5] = '{pw(80'h12F4, 4),   24'h4BBBBB, 1'b1, 4'h4, 1'b0};
    vec[6] = '{SENHA_NONE,        24'h4BBBBB, 1'b0, 4'h4, 1'b0};
    vec[7] = '{pw(80'h98765, 5),  24'h4BBBBB, 1'b0, 4'h5, 1'b0};
    vec[8] = '{pw(80'h4321, 4),   24'h5BBBBB, 1'b0, 4'h6, 1'b0};
    vec[9] = '{SENHA_SKIP,        24'h6BBBBB, 1'b0, 4'hB, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_display_en", bus.display_en, 1'b0);
    chk("rst_bcd", bus.bcd_pac, 24'hBBBBBB);
    chk("rst_ok", bus.data_setup_ok, 1'b0);
    chk("rst_abort", bus.setup_abort, 1'b0);
    chk("rst_err", bus.entry_err, 1'b0);
    chk("rst_bip_status", bus.data_setup_new.bip_status, 1'b1);
    chk("rst_bip_time", bus.data_setup_new.bip_time, 7'd5);
    chk("rst_trc_time", bus.data_setup_new.tranca_aut_time, 7'd5);
    chk("rst_master", bus.data_setup_new.senha_master, pw(80'h1234, 4));
    chk("rst_user0", bus.data_setup_new.senha[0], SENHA_SKIP);
    rst = 1'b1;
    @(negedge clk);

    // Session 1: table-driven walk through every field
    enter_setup();
    chk("s1_display_en", bus.display_en, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.digitos_value = vec[i].val;
      #1;
      chk($sformatf("v%0d_bcd_pre", i), bus.bcd_pac, vec[i].bcd_pre);
      @(negedge clk);
      send(vec[i].val);
      chk($sformatf("v%0d_err", i), bus.entry_err, vec[i].err);
      chk($sformatf("v%0d_bcd5", i), bus.bcd_pac[5], vec[i].bcd5);
      chk($sformatf("v%0d_ok", i), bus.data_setup_ok, vec[i].ok);
    end
    @(negedge clk);
    chk("s1_ok_gone", bus.data_setup_ok, 1'b0);
    chk("s1_idle", bus.display_en, 1'b0);
    chk("s1_bip_status", bus.data_setup_new.bip_status, 1'b0);
    chk("s1_bip_time", bus.data_setup_new.bip_time, 7'd5);
    chk("s1_trc_time", bus.data_setup_new.tranca_aut_time, 7'd60);
    chk("s1_master", bus.data_setup_new.senha_master, pw(80'h98765, 5));
    chk("s1_user0", bus.data_setup_new.senha[0], pw(80'h4321, 4));
    chk("s1_user1", bus.data_setup_new.senha[1], SENHA_SKIP);
    for (int s = 2; s < 5; s++)
      chk($sformatf("s1_unused%0d", s), bus.data_setup_new.senha[s], SENHA_SKIP);

    // Session 2: canonical sequence
    enter_setup();
    send(pw(80'h0, 1));
    send(pw(80'h07, 2));
    send(pw(80'h99, 2));
    send(pw(80'h1234, 4));
    send(SENHA_SKIP);
    chk("s2_not_yet", bus.data_setup_ok, 1'b0);
    send(SENHA_SKIP);
    chk("s2_ok", bus.data_setup_ok, 1'b1);
    @(negedge clk);
    chk("s2_ok_one_pulse", bus.data_setup_ok, 1'b0);
    chk("s2_bip_status", bus.data_setup_new.bip_status, 1'b0);
    chk("s2_bip_time", bus.data_setup_new.bip_time, 7'd7);
    chk("s2_trc_time", bus.data_setup_new.tranca_aut_time, 7'd60);
    chk("s2_master", bus.data_setup_new.senha_master, pw(80'h1234, 4));
    chk("s2_user0_kept", bus.data_setup_new.senha[0], pw(80'h4321, 4));

    // Session 3: save from T_TRC
    enter_setup();
    send(pw(80'h1, 1));
    send(pw(80'h12, 2));
    send(SENHA_SAVE);
    chk("s3_ok", bus.data_setup_ok, 1'b1);
    chk("s3_err", bus.entry_err, 1'b0);
    @(negedge clk);
    chk("s3_bip_status", bus.data_setup_new.bip_status, 1'b1);
    chk("s3_bip_time", bus.data_setup_new.bip_time, 7'd12);
    chk("s3_trc_time", bus.data_setup_new.tranca_aut_time, 7'd60);
    chk("s3_master", bus.data_setup_new.senha_master, pw(80'h1234, 4));

    // Session 4: inactivity abort while on user 2
    enter_setup();
    repeat (4) send(SENHA_SKIP);
    chk("s4_user1_field", bus.bcd_pac[5], 4'h5);
    send(pw(80'h5555, 4));
    chk("s4_user2_field", bus.bcd_pac[5], 4'h6);
    n_ab  = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.setup_abort) begin
        n_ab++;
        if (first == 0) first = c;
      end
    end
    chk("s4_abort_count", n_ab, 1);
    chk("s4_abort_latency", first, 16);
    chk("s4_idle", bus.display_en, 1'b0);
    chk("s4_user0_kept", bus.data_setup_new.senha[0], pw(80'h4321, 4));
    chk("s4_bip_time_kept", bus.data_setup_new.bip_time, 7'd12);

    // Session 5: reset in the middle of S_USER
    enter_setup();
    repeat (4) send(SENHA_SKIP);
    chk("s5_in_user", bus.bcd_pac[5], 4'h5);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_idle", bus.display_en, 1'b0);
    chk("s5_ok", bus.data_setup_ok, 1'b0);
    chk("s5_abort", bus.setup_abort, 1'b0);
    chk("s5_bip_status", bus.data_setup_new.bip_status, 1'b1);
    chk("s5_bip_time", bus.data_setup_new.bip_time, 7'd5);
    chk("s5_trc_time", bus.data_setup_new.tranca_aut_time, 7'd5);
    chk("s5_user0", bus.data_setup_new.senha[0], SENHA_SKIP);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_after_ok", bus.data_setup_ok, 1'b0);
    chk("s5_after_abort", bus.setup_abort, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
